// File: rtl/decoder_nto2n_seq_pkg.sv
// Shared types and constants for the sequenced N-to-2^N one-hot decoder.
// Holds the FSM state encoding, the mode constants and a one-hot helper.
package decoder_nto2n_seq_pkg;

  localparam int PKG_SEL_W = 3;
  localparam int PKG_OUT_W = 1 << PKG_SEL_W;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2,
    ST_BUBBLE = 2'd3
  } state_t;

  // Reference-width encoder for code outside the parametrised datapath.
  function automatic logic [PKG_OUT_W-1:0] onehot_encode(input logic [PKG_SEL_W-1:0] sel);
    logic [PKG_OUT_W-1:0] v;
    v      = '0;
    v[sel] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_nto2n_seq_onehot_encode_comb.sv
// Purely combinational SEL_W -> 2^SEL_W one-hot encoder with an enable gate.
// A deasserted enable yields an all-zero vector.
module onehot_encode_comb #(
  parameter int SEL_W = 3,
  parameter int OUT_W = 2**SEL_W
) (
  input  logic             i_en,
  input  logic [SEL_W-1:0] i_sel,
  output logic [OUT_W-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    for (int i = 0; i < OUT_W; i++) begin
      o_onehot[i] = i_en && (i_sel == SEL_W'(i));
    end
  end

endmodule

// File: rtl/decoder_nto2n_seq.sv
// Registered N-to-2^N one-hot decoder with valid/ready output handshake,
// a 1-deep output register and an autonomous walking-one scan mode.
module decoder_nto2n_seq
  import decoder_nto2n_seq_pkg::*;
#(
  parameter int SEL_W = 3,
  parameter int OUT_W = 2**SEL_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             mode,
  input  logic             in_valid,
  input  logic [SEL_W-1:0] in_sel,
  output logic             in_ready,
  output logic [OUT_W-1:0] out,
  output logic [SEL_W-1:0] out_idx,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             wrap,
  output state_t           dbg_state
);

  // Handshakes: a transfer happens on a clock edge where valid && ready are
  // both high; valid never waits on ready, and held data stays stable.

  state_t           r_state;
  state_t           w_state_nxt;
  logic [SEL_W-1:0] r_idx;
  logic [SEL_W-1:0] w_idx_nxt;
  logic             r_valid;
  logic             w_valid_nxt;
  logic             r_wrap;
  logic             w_wrap_nxt;
  logic [OUT_W-1:0] r_out;
  logic [OUT_W-1:0] w_out_nxt;

  logic             w_direct_live;
  logic             w_accept;
  logic             w_consume;
  logic [SEL_W-1:0] w_scan_start;

  // Ready only when this cycle's edge will really stay in DIRECT, so an
  // accepted value is never silently dropped by reset, disable or mode change.
  assign w_direct_live = rst_n && enable && (mode == MODE_DIRECT) && (r_state == ST_DIRECT);
  assign in_ready      = w_direct_live && (!r_valid || out_ready);
  assign w_accept      = in_valid && in_ready;
  assign w_consume     = r_valid && out_ready;
  assign w_scan_start  = in_valid ? in_sel : '0;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_valid_nxt = r_valid;
    w_wrap_nxt  = 1'b0;

    if (!enable) begin
      w_state_nxt = ST_IDLE;
      w_idx_nxt   = '0;
      w_valid_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_BUBBLE: begin
          if (mode == MODE_SCAN) begin
            w_state_nxt = ST_SCAN;
            w_idx_nxt   = w_scan_start;
            w_valid_nxt = 1'b1;
          end else begin
            w_state_nxt = ST_DIRECT;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
          end
        end
        ST_DIRECT: begin
          if (mode != MODE_DIRECT) begin
            w_state_nxt = ST_BUBBLE;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
          end else if (w_accept) begin
            w_idx_nxt   = in_sel;
            w_valid_nxt = 1'b1;
          end else if (w_consume) begin
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
          end
        end
        ST_SCAN: begin
          if (mode != MODE_SCAN) begin
            w_state_nxt = ST_BUBBLE;
            w_idx_nxt   = '0;
            w_valid_nxt = 1'b0;
          end else begin
            w_valid_nxt = 1'b1;
            if (out_ready) begin
              // SEL_W-bit counter wraps on its own; all-ones marks the wrap.
              w_idx_nxt  = r_idx + 1'b1;
              w_wrap_nxt = &r_idx;
            end
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_idx_nxt   = '0;
          w_valid_nxt = 1'b0;
        end
      endcase
    end
  end

  onehot_encode_comb #(
    .SEL_W (SEL_W),
    .OUT_W (OUT_W)
  ) u_enc (
    .i_en     (w_valid_nxt),
    .i_sel    (w_idx_nxt),
    .o_onehot (w_out_nxt)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
      r_out   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_valid <= w_valid_nxt;
      r_wrap  <= w_wrap_nxt;
      r_out   <= w_out_nxt;
    end
  end

  assign out       = r_out;
  assign out_idx   = r_idx;
  assign out_valid = r_valid;
  assign wrap      = r_wrap;
  assign dbg_state = r_state;

endmodule

// File: doc/decoder_nto2n_seq.md
Name: decoder_nto2n_seq

Overview:
- Parametrised, registered N-to-2^N one-hot decoder. Successor to the fixed 3-to-8 combinational decoder.
- Adds a valid/ready output handshake, a 1-deep output register, and an autonomous scan mode that sweeps the one-hot output across all lines.
- Drives row/lane select strobes in the adder datapath and its test fixtures, e.g. a walking-one stimulus generator.

Parameters:
- SEL_W, 3, select width N.
- OUT_W, 2**SEL_W, output line count (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low.
- enable  input  1  block enable; 0 forces IDLE.
- mode  input  1  0 = DIRECT decode, 1 = SCAN.
- in_valid  input  1  in_sel valid.
- in_sel  input  SEL_W  index to decode (DIRECT); scan start index (SCAN entry).
- in_ready  output  1  input accepted when in_valid && in_ready.
- out  output  OUT_W  registered one-hot line, or all-zero.
- out_idx  output  SEL_W  binary index of the set bit in out.
- out_valid  output  1  out/out_idx valid.
- out_ready  input  1  downstream consumes on out_valid && out_ready.
- wrap  output  1  single-cycle pulse on a SCAN wrap from OUT_W-1 to 0.

Behaviour:
- Reset: synchronous, rst_n sampled at the clk edge. Forces state=IDLE, out=0, out_idx=0, out_valid=0, wrap=0. in_ready=0 while state is IDLE.
- Invariant: out == one-hot(out_idx) when out_valid=1; out == 0 when out_valid=0.
- FSM states: IDLE, DIRECT, SCAN, BUBBLE.
- IDLE:
  - enable=1 && mode=0 -> DIRECT.
  - enable=1 && mode=1 -> SCAN. Start idx = in_sel if in_valid, else 0. Output is visible the cycle after entry.
- Any state with enable=0: next cycle is IDLE and outputs are cleared.
- Mode change while in DIRECT or SCAN: next cycle is BUBBLE (outputs cleared, in_ready=0). The cycle after, the FSM enters the mode then present, or IDLE if enable=0. A pending DIRECT output is discarded on a mode change.
- DIRECT:
  - in_ready = !out_valid || out_ready, so back-to-back transfers are possible.
  - On accept, next cycle: out=one-hot(in_sel), out_idx=in_sel, out_valid=1. Latency is 1 cycle.
  - Output holds stable while out_valid && !out_ready.
  - Consume with no new accept: out_valid=0, out=0 next cycle.
  - Simultaneous consume and accept: the new value is loaded with no bubble.
- SCAN:
  - in_ready=0 and out_valid=1 continuously.
  - On each out_valid && out_ready, out_idx advances by 1.
  - Advance from OUT_W-1 wraps to 0 and asserts wrap for exactly that cycle, aligned with out_idx=0.
  - out_ready=0 stalls the index and keeps wrap=0.
- Width rules: the index counter is SEL_W bits and wraps naturally, with no extra logic. An in_sel of any value is legal since 2^SEL_W == OUT_W.
- Reset mid-operation overrides every other input that cycle.

Decomposition:
- Shared package holds:
  - the state enum typedef (IDLE, DIRECT, SCAN, BUBBLE);
  - MODE_DIRECT=0 and MODE_SCAN=1 constants;
  - a one-hot encode function, SEL_W-parametrised via localparam.
- One natural sub-module, onehot_encode_comb: purely combinational SEL_W -> OUT_W, enable-gated.
  - It is reused by the FSM register stage and the verification scoreboard.

Test Plan:
- Reset: hold rst_n=0 two cycles with enable=1, mode=1 -> out=8'h00, out_valid=0, wrap=0, in_ready=0.
- DIRECT stream: enable=1, mode=0, out_ready=1, in_sel 0..7 on consecutive cycles -> out 8'h01, 8'h02 ... 8'h80, each 1 cycle after its accept, no bubbles.
- Backpressure: accept in_sel=3'b101 and hold out_ready=0 for 4 cycles -> out=8'h20 stable and in_ready=0. Release -> next in_sel=3'b010 gives out=8'h04 on the cycle after the consume.
- SCAN wrap: mode=1 entered with in_valid=1, in_sel=6, out_ready=1 -> out 8'h40, 8'h80, then 8'h01 with wrap=1 for that single cycle, then 8'h02. Stalling out_ready mid-scan freezes out_idx.
- Mode change: in SCAN at out_idx=4, toggle mode to 0 -> BUBBLE cycle (out=0, out_valid=0), then DIRECT with in_ready=1.
- Enable drop: out_valid=1 in DIRECT, then enable=0 -> next cycle out=0, out_valid=0, state IDLE.
- Synchronous reset mid-SCAN: assert rst_n=0 at out_idx=3 -> next edge clears outputs; no wrap pulse is produced.
